// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage for the 10-bit processor.
// Owns the program counter, folds unconditional jumps locally, accepts
// taken-branch redirects from execute, freezes on a halt instruction and
// counts every instruction it hands to decode.
module fetch_unit #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned INSTR_W  = 10,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  rom_address,
  input  logic [INSTR_W-1:0] rom_data,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  output logic               halted,
  output logic [CNT_W-1:0]   fetch_count
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  localparam logic [INSTR_W-1:0] HALT_WORD = INSTR_W'(10'b0010000010);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
  logic               instr_valid_q, instr_valid_d;
  logic               halted_q, halted_d;
  logic [CNT_W-1:0]   fetch_count_q, fetch_count_d;

  logic               is_jump;
  logic               is_halt;
  logic [ADDR_W-1:0]  jump_target;

  // Decode the word coming back from the ROM for jump and halt detection.
  always_comb begin
    is_jump     = (rom_data[9:6] == 4'b1000);
    is_halt     = (rom_data == HALT_WORD);
    jump_target = ADDR_W'(rom_data[5:0]);
  end

  // Next-state logic: redirect beats stall, stall beats jump, jump beats halt.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    halted_d      = halted_q;
    fetch_count_d = fetch_count_q;
    unique case (state_q)
      ST_RUN: begin
        if (redirect_valid) begin
          pc_d          = redirect_target;
          instr_valid_d = 1'b0;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (is_jump) begin
          pc_d          = jump_target;
          instr_valid_d = 1'b0;
        end else if (is_halt) begin
          instr_d       = rom_data;
          instr_pc_d    = pc_q;
          instr_valid_d = 1'b1;
          fetch_count_d = fetch_count_q + CNT_W'(1);
          halted_d      = 1'b1;
          state_d       = ST_HALTED;
        end else begin
          instr_d       = rom_data;
          instr_pc_d    = pc_q;
          instr_valid_d = 1'b1;
          fetch_count_d = fetch_count_q + CNT_W'(1);
          pc_d          = pc_q + ADDR_W'(1);
        end
      end
      ST_HALTED: begin
        instr_valid_d = 1'b0;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_RUN;
      pc_q          <= ADDR_W'(RESET_PC);
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign rom_address = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign halted      = halted_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven bench for fetch_unit with a behavioural ROM
// and a queue of expected post-edge states.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic [9:0]  rom_address;
  logic [9:0]  rom_data;
  logic        stall;
  logic        redirect_valid;
  logic [9:0]  redirect_target;
  logic [9:0]  instr;
  logic [9:0]  instr_pc;
  logic        instr_valid;
  logic        halted;
  logic [15:0] fetch_count;

  logic [9:0] rom [1024];

  int tests_run = 0;
  int failures  = 0;

  typedef struct {
    logic        stall;
    logic        rv;
    logic [9:0]  rt;
    logic [9:0]  e_pc;
    logic [9:0]  e_instr;
    logic [9:0]  e_ipc;
    logic        e_valid;
    logic [15:0] e_cnt;
    logic        e_halted;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  fetch_unit #(
    .ADDR_W(10), .INSTR_W(10), .RESET_PC(0), .CNT_W(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rom_address(rom_address),
    .rom_data(rom_data),
    .stall(stall),
    .redirect_valid(redirect_valid),
    .redirect_target(redirect_target),
    .instr(instr),
    .instr_pc(instr_pc),
    .instr_valid(instr_valid),
    .halted(halted),
    .fetch_count(fetch_count)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ROM model.
  assign rom_data = rom[rom_address];

  function automatic vec_t mk(input logic s, input logic rv, input logic [9:0] rt,
                              input logic [9:0] pc, input logic [9:0] ins,
                              input logic [9:0] ipc, input logic v,
                              input logic [15:0] c, input logic h);
    vec_t r;
    r.stall = s; r.rv = rv; r.rt = rt;
    r.e_pc = pc; r.e_instr = ins; r.e_ipc = ipc;
    r.e_valid = v; r.e_cnt = c; r.e_halted = h;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkNow(input string tag, input vec_t e);
    check($sformatf("%s rom_address", tag), 32'(rom_address), 32'(e.e_pc));
    check($sformatf("%s instr", tag), 32'(instr), 32'(e.e_instr));
    check($sformatf("%s instr_pc", tag), 32'(instr_pc), 32'(e.e_ipc));
    check($sformatf("%s instr_valid", tag), 32'(instr_valid), 32'(e.e_valid));
    check($sformatf("%s fetch_count", tag), 32'(fetch_count), 32'(e.e_cnt));
    check($sformatf("%s halted", tag), 32'(halted), 32'(e.e_halted));
  endtask

  task automatic applyStimulus(input vec_t v);
    stall           = v.stall;
    redirect_valid  = v.rv;
    redirect_target = v.rt;
    sb.push_back(v);
  endtask

  task automatic checkOutput(input string tag);
    vec_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      tests_run++;
      failures++;
      $display("[TB] FAIL %s scoreboard: got empty queue, expected an entry", tag);
    end else begin
      e = sb.pop_front();
      checkNow(tag, e);
    end
  endtask

  initial begin
    vec_t rst_vals;

    for (int i = 0; i < 1024; i++) rom[i] = 10'h300 | 10'(i[5:0]);
    rom[0]  = 10'b0000000001;
    rom[1]  = 10'b1101010000;
    rom[2]  = 10'b0000000000;
    rom[6]  = 10'b1000001000;
    rom[7]  = 10'b1000001100;
    rom[8]  = 10'b1101001000;
    rom[12] = 10'b0000000001;
    rom[33] = 10'b0010000010;

    rst_vals = mk(0, 0, 0, 10'd0, 10'h000, 10'd0, 0, 16'd0, 0);

    // Main program walk: first fetches, stall, redirect+stall, jumps, halt.
    vecs.push_back(mk(0, 0, 0,  10'd1,  10'h001, 10'd0,  1, 16'd1,  0));
    vecs.push_back(mk(0, 0, 0,  10'd2,  10'h350, 10'd1,  1, 16'd2,  0));
    vecs.push_back(mk(1, 0, 0,  10'd2,  10'h350, 10'd1,  1, 16'd2,  0));
    vecs.push_back(mk(1, 0, 0,  10'd2,  10'h350, 10'd1,  1, 16'd2,  0));
    vecs.push_back(mk(1, 0, 0,  10'd2,  10'h350, 10'd1,  1, 16'd2,  0));
    vecs.push_back(mk(0, 0, 0,  10'd3,  10'h000, 10'd2,  1, 16'd3,  0));
    vecs.push_back(mk(0, 0, 0,  10'd4,  10'h303, 10'd3,  1, 16'd4,  0));
    vecs.push_back(mk(0, 0, 0,  10'd5,  10'h304, 10'd4,  1, 16'd5,  0));
    vecs.push_back(mk(1, 1, 7,  10'd7,  10'h304, 10'd4,  0, 16'd5,  0));
    vecs.push_back(mk(0, 0, 0,  10'd12, 10'h304, 10'd4,  0, 16'd5,  0));
    vecs.push_back(mk(0, 0, 0,  10'd13, 10'h001, 10'd12, 1, 16'd6,  0));
    vecs.push_back(mk(0, 1, 6,  10'd6,  10'h001, 10'd12, 0, 16'd6,  0));
    vecs.push_back(mk(0, 0, 0,  10'd8,  10'h001, 10'd12, 0, 16'd6,  0));
    vecs.push_back(mk(0, 0, 0,  10'd9,  10'h348, 10'd8,  1, 16'd7,  0));
    vecs.push_back(mk(0, 1, 30, 10'd30, 10'h348, 10'd8,  0, 16'd7,  0));
    vecs.push_back(mk(0, 0, 0,  10'd31, 10'h31E, 10'd30, 1, 16'd8,  0));
    vecs.push_back(mk(0, 0, 0,  10'd32, 10'h31F, 10'd31, 1, 16'd9,  0));
    vecs.push_back(mk(0, 0, 0,  10'd33, 10'h320, 10'd32, 1, 16'd10, 0));
    vecs.push_back(mk(0, 0, 0,  10'd33, 10'h082, 10'd33, 1, 16'd11, 1));
    vecs.push_back(mk(0, 1, 0,  10'd33, 10'h082, 10'd33, 0, 16'd11, 1));
    vecs.push_back(mk(1, 0, 0,  10'd33, 10'h082, 10'd33, 0, 16'd11, 1));
    vecs.push_back(mk(0, 0, 0,  10'd33, 10'h082, 10'd33, 0, 16'd11, 1));

    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    #1;
    checkNow("reset", rst_vals);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i));
    end

    // Halt and redirect in the same cycle: the redirect wins.
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkNow("reset2", rst_vals);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(mk(0, 1, 33, 10'd33, 10'h000, 10'd0, 0, 16'd0, 0));
    checkOutput("to_halt");
    applyStimulus(mk(0, 1, 0,  10'd0,  10'h000, 10'd0, 0, 16'd0, 0));
    checkOutput("halt_vs_redirect");
    applyStimulus(mk(0, 0, 0,  10'd1,  10'h001, 10'd0, 1, 16'd1, 0));
    checkOutput("after_redirect");

    // Program counter wraps from 1023 to 0.
    applyStimulus(mk(0, 1, 1023, 10'd1023, 10'h001, 10'd0,    0, 16'd1, 0));
    checkOutput("to_1023");
    applyStimulus(mk(0, 0, 0,    10'd0,    10'h33F, 10'd1023, 1, 16'd2, 0));
    checkOutput("pc_wrap");

    // Asynchronous reset asserted mid-cycle at pc=15.
    applyStimulus(mk(0, 1, 15, 10'd15, 10'h33F, 10'd1023, 0, 16'd2, 0));
    checkOutput("to_15");
    stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    #2;
    reset = 1'b1;
    #1;
    checkNow("async_reset", rst_vals);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(mk(0, 0, 0, 10'd1, 10'h001, 10'd0, 1, 16'd1, 0));
    checkOutput("restart");

    if (sb.size() != 0) begin
      tests_run++;
      failures++;
      $display("[TB] FAIL scoreboard_drain: got %0d left, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the 10-bit processor. It sits directly upstream of the instruction ROM and the decode stage. It owns the program counter, drives the ROM address, and registers the returned word into an instruction register for decode. Unconditional jumps are folded locally, taken-branch redirects are accepted from execute, halt is detected locally, and the unit keeps a count of issued instructions.

## Interface
Parameters:
- ADDR_W, 10, program counter / ROM address width
- INSTR_W, 10, instruction width
- RESET_PC, 0, program counter value after reset
- CNT_W, 16, width of fetch_count

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- rom_address  out  ADDR_W  ROM read address; combinationally equal to pc
- rom_data  in  INSTR_W  ROM read data; combinational, valid in the same cycle as rom_address
- stall  in  1  decode back-pressure; hold all fetch state
- redirect_valid  in  1  taken branch from execute
- redirect_target  in  ADDR_W  branch target address
- instr  out  INSTR_W  registered instruction to decode
- instr_pc  out  ADDR_W  address that instr was fetched from
- instr_valid  out  1  instr is a real instruction, not a bubble
- halted  out  1  halt instruction issued; fetch is frozen
- fetch_count  out  CNT_W  number of instructions issued with instr_valid=1

## Operation
- Two-state machine.
  - RUN: fetching.
  - HALTED: frozen; exited only by reset.
- Decoding happens on rom_data in RUN.
  - Jump: rom_data[9:6]==4'b1000. Target is {4'b0, rom_data[5:0]}.
  - Halt: rom_data==10'b0010000010.
- Each edge in RUN applies the first matching rule below (priority order):
  1. redirect_valid=1:
     - pc <= redirect_target; instr_valid <= 0.
     - instr and instr_pc are unchanged; fetch_count is unchanged.
     - Takes precedence over stall, jump and halt in the same cycle.
  2. stall=1: pc, instr, instr_pc, instr_valid and fetch_count all hold.
  3. Jump fetched:
     - pc <= jump target; instr_valid <= 0.
     - The jump is folded and never issued to decode; fetch_count is unchanged.
  4. Halt fetched:
     - instr <= rom_data, instr_pc <= pc, instr_valid <= 1, fetch_count += 1.
     - pc holds; halted <= 1; state -> HALTED.
  5. Otherwise:
     - instr <= rom_data, instr_pc <= pc, instr_valid <= 1, fetch_count += 1.
     - pc <= pc + 1 (mod 2^ADDR_W).
- HALTED:
  - pc, instr and instr_pc hold; instr_valid <= 0 after the first edge; halted stays 1.
  - redirect_valid and stall are ignored.
- Arithmetic:
  - pc wraps from 1023 to 0.
  - fetch_count wraps at 2^CNT_W.
  - Jump targets are zero-extended from 6 bits.
- Reset values (asynchronous, applied immediately on reset=1):
  - pc=RESET_PC, rom_address=RESET_PC, state=RUN.
  - instr=0, instr_pc=0, instr_valid=0, halted=0, fetch_count=0.

## Timing
- Fetch latency: the word at address A is on instr, with instr_pc=A, one edge after pc==A (given no stall and no redirect).
- First instruction: instr_valid=1 after the first rising edge following reset deassertion.
- Jump penalty: one bubble cycle (instr_valid=0); the target instruction appears on instr two edges after the jump's address was on rom_address.
- Redirect penalty: one bubble cycle. The instruction fetched in the redirect cycle is discarded.
- Stall: zero-cycle response; state is held at the edge where stall=1 is sampled.
- A halt and a redirect in the same cycle: the redirect wins, and halt is not entered.
- halted rises on the same edge that issues the halt instruction. instr_valid drops on the next edge.
- Reset deassertion takes effect synchronously with the next rising edge; there is no partial-cycle state.

## Test plan
- Reset, then run 3 cycles with the ROM program loaded: instr_pc=0,1,2 with instr=0000000001, 1101010000, 0000000000; instr_valid=1; fetch_count=3.
- Jump folding at pc=6 (word 1000001000): next edge pc=8 and instr_valid=0; following edge instr=1101001000, instr_pc=8; fetch_count does not count the jump.
- Redirect with redirect_valid=1, target=7 at pc=5, stall also high: next edge pc=7, instr_valid=0. Then the jump at 7 folds to pc=12, and instr_pc=12 with instr=0000000001 appears two edges later.
- stall high for 3 cycles at pc=2: rom_address, instr, instr_pc, instr_valid and fetch_count are constant; fetch resumes at pc=2 when stall drops.
- Run to pc=33 (word 0010000010): instr=0010000010 issued once with instr_valid=1 and halted=1. Afterwards instr_valid=0 and pc=33 forever; redirect_valid=1 with target=0 is ignored.
- Assert reset mid-cycle at pc=15: all outputs take reset values before the next edge. After deassertion, fetch restarts at pc=0 with fetch_count=0.
